// File: rtl/branch_predictor_bht.sv
// Direct-mapped BHT+BTB: combinational fetch lookup, execute-side mispredict/redirect and table update.
// Optional BP_STATS_EN adds saturating branch and mispredict counters.
module branch_predictor_bht #(
  parameter int         ENTRIES  = 16,
  parameter logic [1:0] CTR_INIT = 2'b01
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] if_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        ex_valid,
  input  logic        ex_is_branch,
  input  logic [31:0] ex_pc,
  input  logic        ex_br_true,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  output logic        mispredict,
  output logic [31:0] redirect_pc
`ifdef BP_STATS_EN
  ,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
`endif
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  function automatic logic [1:0] ctr_inc(input logic [1:0] c);
    return (c == 2'b11) ? c : c + 2'b01;
  endfunction

  function automatic logic [1:0] ctr_dec(input logic [1:0] c);
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

  logic              valid_q  [ENTRIES];
  logic [TAG_W-1:0]  tag_q    [ENTRIES];
  logic [31:0]       target_q [ENTRIES];
  logic [1:0]        ctr_q    [ENTRIES];

  logic [IDX_W-1:0]  lk_idx, ex_idx;
  logic [TAG_W-1:0]  lk_tag, ex_tag;
  logic              lk_hit, ex_hit;
  logic              br_mis, alias_mis;

  // Fetch-side lookup
  assign lk_idx      = if_pc[IDX_W+1:2];
  assign lk_tag      = if_pc[31:IDX_W+2];
  assign lk_hit      = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign pred_taken  = lk_hit && ctr_q[lk_idx][1];
  assign pred_target = pred_taken ? target_q[lk_idx] : if_pc + 32'd4;

  // Execute-side resolution; forced quiet while in reset
  assign ex_idx    = ex_pc[IDX_W+1:2];
  assign ex_tag    = ex_pc[31:IDX_W+2];
  assign ex_hit    = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
  assign br_mis    = ex_is_branch &&
                     ((ex_br_true != ex_pred_taken) ||
                      (ex_br_true && ex_pred_taken && (ex_pred_target != ex_target)));
  assign alias_mis = !ex_is_branch && ex_pred_taken;
  assign mispredict  = rst_n && ex_valid && (br_mis || alias_mis);
  assign redirect_pc = (ex_valid && ex_is_branch && ex_br_true) ? ex_target : ex_pc + 32'd4;

  // Table update; reset takes priority and drops any in-flight update
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_INIT;
      end
    end else if (ex_valid) begin
      if (ex_is_branch) begin
        if (ex_hit) begin
          if (ex_br_true) begin
            ctr_q[ex_idx]    <= ctr_inc(ctr_q[ex_idx]);
            target_q[ex_idx] <= ex_target;
          end else begin
            ctr_q[ex_idx]    <= ctr_dec(ctr_q[ex_idx]);
          end
        end else if (ex_br_true) begin
          valid_q[ex_idx]  <= 1'b1;
          tag_q[ex_idx]    <= ex_tag;
          target_q[ex_idx] <= ex_target;
          ctr_q[ex_idx]    <= 2'b10;
        end
      end else if (ex_pred_taken && ex_hit) begin
        valid_q[ex_idx] <= 1'b0;
      end
    end
  end

`ifdef BP_STATS_EN
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (ex_valid && ex_is_branch) stat_branches <= sat_inc32(stat_branches);
      if (mispredict)               stat_mispredicts <= sat_inc32(stat_mispredicts);
    end
  end
`endif

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Directed self-checking bench for branch_predictor_bht (ENTRIES=16).
module tb_branch_predictor_bht;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid, ex_is_branch, ex_br_true, ex_pred_taken;
  logic [31:0] ex_pc, ex_target, ex_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc;
`ifdef BP_STATS_EN
  logic [31:0] stat_branches, stat_mispredicts;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  branch_predictor_bht #(.ENTRIES(16), .CTR_INIT(2'b01)) dut (
    .clk(clk), .rst_n(rst_n), .if_pc(if_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_pc(ex_pc),
    .ex_br_true(ex_br_true), .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .mispredict(mispredict), .redirect_pc(redirect_pc)
`ifdef BP_STATS_EN
    , .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
`endif
  );

  // Advance one clock, leaving inputs 1ns past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ex(input logic v, input logic br, input logic [31:0] pc,
                          input logic bt, input logic [31:0] tgt,
                          input logic pt, input logic [31:0] ptgt);
    ex_valid = v; ex_is_branch = br; ex_pc = pc; ex_br_true = bt;
    ex_target = tgt; ex_pred_taken = pt; ex_pred_target = ptgt;
    #1;
  endtask

  task automatic idle();
    drive_ex(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic look(input logic [31:0] pc);
    if_pc = pc;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    if_pc = 32'h100;
    drive_ex(1'b1, 1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
    total++; if (mispredict !== 1'b0) begin bad++; $display("FAIL reset_mispredict got=%0h exp=0", mispredict); end
    tick();
    tick();
    rst_n = 1'b1;
    idle();
    look(32'h100);
    total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL reset_pred_taken got=%0h exp=0", pred_taken); end
    total++; if (pred_target !== 32'h104) begin bad++; $display("FAIL reset_pred_target got=%h exp=00000104", pred_target); end
  endtask

  task automatic test_allocate();
    look(32'h100);
    drive_ex(1'b1, 1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
    total++; if (mispredict !== 1'b1) begin bad++; $display("FAIL alloc_mispredict got=%0h exp=1", mispredict); end
    total++; if (redirect_pc !== 32'h80) begin bad++; $display("FAIL alloc_redirect got=%h exp=00000080", redirect_pc); end
    total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL same_cycle_old_entry got=%0h exp=0", pred_taken); end
    tick();
    idle();
    total++; if (pred_taken !== 1'b1) begin bad++; $display("FAIL alloc_pred_taken got=%0h exp=1", pred_taken); end
    total++; if (pred_target !== 32'h80) begin bad++; $display("FAIL alloc_pred_target got=%h exp=00000080", pred_target); end
  endtask

  // Counter starts at 10 after allocation; ends at 11 with target 0x80.
  task automatic test_counter();
    look(32'h100);
    drive_ex(1'b1, 1'b1, 32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
    total++; if (mispredict !== 1'b1) begin bad++; $display("FAIL nt_mispredict got=%0h exp=1", mispredict); end
    total++; if (redirect_pc !== 32'h104) begin bad++; $display("FAIL nt_redirect got=%h exp=00000104", redirect_pc); end
    tick(); idle();
    total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL ctr01_pred got=%0h exp=0", pred_taken); end
    drive_ex(1'b1, 1'b1, 32'h100, 1'b0, 32'h80, 1'b0, 32'h104);
    total++; if (mispredict !== 1'b0) begin bad++; $display("FAIL nt_correct_mispredict got=%0h exp=0", mispredict); end
    tick();
    drive_ex(1'b1, 1'b1, 32'h100, 1'b0, 32'h80, 1'b0, 32'h104);
    tick();
    drive_ex(1'b1, 1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
    tick(); idle();
    total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL ctr_floor_pred got=%0h exp=0", pred_taken); end
    drive_ex(1'b1, 1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
    tick(); idle();
    total++; if (pred_taken !== 1'b1) begin bad++; $display("FAIL ctr10_pred got=%0h exp=1", pred_taken); end
    for (int i = 0; i < 3; i++) begin
      drive_ex(1'b1, 1'b1, 32'h100, 1'b1, 32'h80, 1'b1, 32'h80);
      total++; if (mispredict !== 1'b0) begin bad++; $display("FAIL taken_hit_mispredict_%0d got=%0h exp=0", i, mispredict); end
      tick();
    end
    drive_ex(1'b1, 1'b1, 32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
    tick(); idle();
    total++; if (pred_taken !== 1'b1) begin bad++; $display("FAIL ctr_ceiling_pred got=%0h exp=1", pred_taken); end
    drive_ex(1'b1, 1'b1, 32'h100, 1'b1, 32'h80, 1'b1, 32'h80);
    tick(); idle();
  endtask

  task automatic test_target_change();
    look(32'h100);
    drive_ex(1'b1, 1'b1, 32'h100, 1'b1, 32'h90, 1'b1, 32'h80);
    total++; if (mispredict !== 1'b1) begin bad++; $display("FAIL tgt_mispredict got=%0h exp=1", mispredict); end
    total++; if (redirect_pc !== 32'h90) begin bad++; $display("FAIL tgt_redirect got=%h exp=00000090", redirect_pc); end
    tick(); idle();
    total++; if (pred_target !== 32'h90) begin bad++; $display("FAIL tgt_new_target got=%h exp=00000090", pred_target); end
    total++; if (pred_taken !== 1'b1) begin bad++; $display("FAIL tgt_pred_taken got=%0h exp=1", pred_taken); end
  endtask

  task automatic test_alias();
    look(32'h140);
    total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL alias_lookup_pred got=%0h exp=0", pred_taken); end
    total++; if (pred_target !== 32'h144) begin bad++; $display("FAIL alias_lookup_target got=%h exp=00000144", pred_target); end
    drive_ex(1'b1, 1'b0, 32'h140, 1'b0, 32'h0, 1'b1, 32'h90);
    total++; if (mispredict !== 1'b1) begin bad++; $display("FAIL alias_miss_mispredict got=%0h exp=1", mispredict); end
    tick(); idle();
    look(32'h100);
    total++; if (pred_taken !== 1'b1) begin bad++; $display("FAIL alias_tagmiss_keep got=%0h exp=1", pred_taken); end
    drive_ex(1'b1, 1'b0, 32'h100, 1'b0, 32'h0, 1'b1, 32'h90);
    total++; if (mispredict !== 1'b1) begin bad++; $display("FAIL alias_mispredict got=%0h exp=1", mispredict); end
    total++; if (redirect_pc !== 32'h104) begin bad++; $display("FAIL alias_redirect got=%h exp=00000104", redirect_pc); end
    tick(); idle();
    total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL alias_invalidated got=%0h exp=0", pred_taken); end
    total++; if (pred_target !== 32'h104) begin bad++; $display("FAIL alias_inv_target got=%h exp=00000104", pred_target); end
  endtask

  task automatic test_no_update();
    look(32'h100);
    drive_ex(1'b0, 1'b1, 32'h100, 1'b1, 32'h80, 1'b1, 32'h90);
    total++; if (mispredict !== 1'b0) begin bad++; $display("FAIL novalid_br_mispredict got=%0h exp=0", mispredict); end
    tick();
    drive_ex(1'b0, 1'b0, 32'h100, 1'b0, 32'h0, 1'b1, 32'h90);
    total++; if (mispredict !== 1'b0) begin bad++; $display("FAIL novalid_alias_mispredict got=%0h exp=0", mispredict); end
    tick(); idle();
    total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL novalid_no_alloc got=%0h exp=0", pred_taken); end
  endtask

  task automatic test_wrap();
    look(32'hFFFF_FFFC);
    total++; if (pred_target !== 32'h0) begin bad++; $display("FAIL wrap_pred_target got=%h exp=00000000", pred_target); end
    drive_ex(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h40, 1'b1, 32'h40);
    total++; if (redirect_pc !== 32'h0) begin bad++; $display("FAIL wrap_redirect got=%h exp=00000000", redirect_pc); end
    tick();
    drive_ex(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'h40, 1'b0, 32'h0);
    tick(); idle();
    total++; if (pred_target !== 32'h40) begin bad++; $display("FAIL wrap_alloc_target got=%h exp=00000040", pred_target); end
    look(32'h13C);
    total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL idx15_other_tag got=%0h exp=0", pred_taken); end
  endtask

  task automatic test_back_to_back();
    look(32'h200);
    drive_ex(1'b1, 1'b1, 32'h200, 1'b1, 32'h300, 1'b0, 32'h204);
    tick();
    drive_ex(1'b1, 1'b1, 32'h200, 1'b1, 32'h300, 1'b1, 32'h300);
    total++; if (pred_taken !== 1'b1) begin bad++; $display("FAIL b2b_pred_taken got=%0h exp=1", pred_taken); end
    total++; if (pred_target !== 32'h300) begin bad++; $display("FAIL b2b_pred_target got=%h exp=00000300", pred_target); end
    total++; if (mispredict !== 1'b0) begin bad++; $display("FAIL b2b_mispredict got=%0h exp=0", mispredict); end
    tick();
    drive_ex(1'b1, 1'b1, 32'h200, 1'b0, 32'h300, 1'b1, 32'h300);
    tick(); idle();
    total++; if (pred_taken !== 1'b1) begin bad++; $display("FAIL b2b_ctr11_pred got=%0h exp=1", pred_taken); end
  endtask

  task automatic test_reset_mid();
    rst_n = 1'b0;
    drive_ex(1'b1, 1'b1, 32'h400, 1'b1, 32'h500, 1'b0, 32'h404);
    total++; if (mispredict !== 1'b0) begin bad++; $display("FAIL midrst_mispredict got=%0h exp=0", mispredict); end
    tick();
    rst_n = 1'b1;
    idle();
    look(32'h200);
    total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL midrst_200 got=%0h exp=0", pred_taken); end
    look(32'hFFFF_FFFC);
    total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL midrst_fffc got=%0h exp=0", pred_taken); end
    look(32'h400);
    total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL midrst_dropped got=%0h exp=0", pred_taken); end
  endtask

`ifdef BP_STATS_EN
  task automatic test_stats();
    rst_n = 1'b0; idle(); tick(); rst_n = 1'b1;
    drive_ex(1'b1, 1'b1, 32'h500, 1'b1, 32'h600, 1'b0, 32'h504); tick();
    drive_ex(1'b1, 1'b1, 32'h500, 1'b1, 32'h600, 1'b1, 32'h600); tick();
    drive_ex(1'b1, 1'b1, 32'h500, 1'b1, 32'h600, 1'b1, 32'h600); tick();
    drive_ex(1'b1, 1'b1, 32'h500, 1'b0, 32'h600, 1'b1, 32'h600); tick();
    drive_ex(1'b1, 1'b1, 32'h500, 1'b1, 32'h600, 1'b1, 32'h600); tick();
    idle(); tick();
    total++; if (stat_branches !== 32'd5) begin bad++; $display("FAIL stat_branches got=%0d exp=5", stat_branches); end
    total++; if (stat_mispredicts !== 32'd2) begin bad++; $display("FAIL stat_mispredicts got=%0d exp=2", stat_mispredicts); end
    rst_n = 1'b0; tick(); rst_n = 1'b1; #1;
    total++; if (stat_branches !== 32'd0) begin bad++; $display("FAIL stat_br_clear got=%0d exp=0", stat_branches); end
    total++; if (stat_mispredicts !== 32'd0) begin bad++; $display("FAIL stat_mp_clear got=%0d exp=0", stat_mispredicts); end
  endtask
`endif

  initial begin
    #1;
    test_reset();
    test_allocate();
    test_counter();
    test_target_change();
    test_alias();
    test_no_update();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
`ifdef BP_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
